// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transmit byte sequencer.
package i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ACK_WAIT,
    ACK_HOLD
  } state_e;

  // Upstream status bundle, registered together.
  typedef struct packed {
    logic byte_done;
    logic nack;
    logic underrun;
  } tx_status_t;

endpackage

// File: rtl/i2c_tx_byte_sequencer_if.sv
// Byte handshake and status between the peripheral control FSM (master)
// and the transmit byte sequencer (slave).
interface i2c_tx_byte_sequencer_if;

  logic                                 tx_en;
  logic [i2c_pkg::BITS_PER_BYTE-1:0]    data_in;
  logic                                 data_valid;
  logic                                 data_ready;
  logic                                 byte_done;
  logic                                 nack;
  logic                                 underrun;

  modport master (
    output tx_en, data_in, data_valid,
    input  data_ready, byte_done, nack, underrun
  );

  modport slave (
    input  tx_en, data_in, data_valid,
    output data_ready, byte_done, nack, underrun
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pad input, with rise/fall
// pulses derived from the synchronised value versus its previous sample.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to the idle (released) bus level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_tx_byte_sequencer.sv
// I2C controller-read transmit stage: shifts bytes MSB-first onto SDA on SCL
// falls and reports the controller ACK/NACK. Clock stretching: I2C_TX_CLOCK_STRETCH_EN.
module i2c_tx_byte_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_scl_in,
  input  logic                     i_sda_in,
  output logic                     o_sda_oe,
  output logic                     o_scl_oe,
  i2c_tx_byte_sequencer_if.slave   bus
);

  localparam logic [BITS_PER_BYTE-1:0] FILL_BYTE = BITS_PER_BYTE'('1);
  localparam logic [BIT_CNT_W-1:0]     LAST_BIT  = BIT_CNT_W'(BITS_PER_BYTE - 1);

  logic w_scl_s, w_scl_rise, w_scl_fall;
  logic w_sda_s, w_sda_rise_unused, w_sda_fall_unused;

  state_e                   r_state,   w_state_nxt;
  logic [BITS_PER_BYTE-1:0] r_shreg,   w_shreg_nxt;
  logic [BIT_CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic                     r_sda_oe,  w_sda_oe_nxt;
  logic                     r_scl_oe,  w_scl_oe_nxt;
  tx_status_t               r_status,  w_status_nxt;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk      (clk),
    .reset    (reset),
    .i_async  (i_scl_in),
    .o_sync   (w_scl_s),
    .o_rise_c (w_scl_rise),
    .o_fall_c (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk      (clk),
    .reset    (reset),
    .i_async  (i_sda_in),
    .o_sync   (w_sda_s),
    .o_rise_c (w_sda_rise_unused),
    .o_fall_c (w_sda_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= FILL_BYTE;
      r_bit_cnt <= '0;
      r_sda_oe  <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_status  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_scl_oe  <= w_scl_oe_nxt;
      r_status  <= w_status_nxt;
    end
  end

  // Next-state logic; a dropped tx_en overrides every state and any SCL edge.
  always_comb begin
    w_state_nxt            = r_state;
    w_shreg_nxt            = r_shreg;
    w_bit_cnt_nxt          = r_bit_cnt;
    w_sda_oe_nxt           = r_sda_oe;
    w_scl_oe_nxt           = 1'b0;
    w_status_nxt.byte_done = 1'b0;
    w_status_nxt.nack      = r_status.nack;
    w_status_nxt.underrun  = 1'b0;

    if (!bus.tx_en) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sda_oe_nxt = 1'b0;
          if (!w_scl_s) begin
            w_state_nxt = LOAD;
          end
        end

        LOAD: begin
          if (bus.data_valid) begin
            w_shreg_nxt   = bus.data_in;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = ~bus.data_in[BITS_PER_BYTE-1];
            w_state_nxt   = SHIFT;
          end else begin
`ifdef I2C_TX_CLOCK_STRETCH_EN
            w_scl_oe_nxt = 1'b1;
`else
            w_shreg_nxt           = FILL_BYTE;
            w_bit_cnt_nxt         = '0;
            w_sda_oe_nxt          = ~FILL_BYTE[BITS_PER_BYTE-1];
            w_status_nxt.underrun = 1'b1;
            w_state_nxt           = SHIFT;
`endif
          end
        end

        SHIFT: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == LAST_BIT) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = ACK_WAIT;
            end else begin
              w_shreg_nxt   = {r_shreg[BITS_PER_BYTE-2:0], r_shreg[BITS_PER_BYTE-1]};
              w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
              w_sda_oe_nxt  = ~r_shreg[BITS_PER_BYTE-2];
            end
          end
        end

        ACK_WAIT: begin
          w_sda_oe_nxt = 1'b0;
          if (w_scl_rise) begin
            w_status_nxt.nack      = w_sda_s;
            w_status_nxt.byte_done = 1'b1;
            w_state_nxt            = ACK_HOLD;
          end
        end

        ACK_HOLD: begin
          if (w_scl_fall) begin
            w_state_nxt = (r_status.nack == I2C_ACK) ? LOAD : IDLE;
          end
        end

        default: begin
          w_state_nxt  = IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_sda_oe       = r_sda_oe;
  assign o_scl_oe       = r_scl_oe;
  assign bus.data_ready = (r_state == LOAD);
  assign bus.byte_done  = r_status.byte_done;
  assign bus.nack       = r_status.nack;
  assign bus.underrun   = r_status.underrun;

endmodule

// File: tb/tb_i2c_tx_byte_sequencer.sv
// Self-checking bench for i2c_tx_byte_sequencer: a controller model clocks SCL
// and answers ACK/NACK; a scoreboard holds expected SDA bits and ACK results.
module tb_i2c_tx_byte_sequencer;
  import i2c_pkg::*;

  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic ctrl_sda_low = 1'b0;
  logic sda_oe, scl_oe, scl_line, sda_line;

  int checks = 0;
  int errors = 0;
  int bd_cnt = 0;
  int ur_cnt = 0;
  bit hs_pending = 1'b0;

  logic [7:0] prod_q[$];
  logic       exp_bits[$];
  logic       exp_nack[$];
  logic       obs_nack[$];

  i2c_tx_byte_sequencer_if bus ();

  assign scl_line = scl & ~scl_oe;
  assign sda_line = ~(sda_oe | ctrl_sda_low);

  i2c_tx_byte_sequencer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_scl_in (scl_line),
    .i_sda_in (sda_line),
    .o_sda_oe (sda_oe),
    .o_scl_oe (scl_oe),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Upstream producer: offers queued bytes, retires one after each handshake.
  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    forever begin
      @(negedge clk);
      if (hs_pending) begin
        if (prod_q.size() > 0) void'(prod_q.pop_front());
        hs_pending = 1'b0;
      end
      if (prod_q.size() > 0) begin
        bus.data_valid = 1'b1;
        bus.data_in    = prod_q[0];
      end else begin
        bus.data_valid = 1'b0;
      end
      if (!reset && bus.tx_en && bus.data_valid && bus.data_ready) hs_pending = 1'b1;
    end
  end

  // Status monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.byte_done === 1'b1) begin
        bd_cnt++;
        obs_nack.push_back(bus.nack);
      end
      if (bus.underrun === 1'b1) ur_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic enqueue_byte(input logic [7:0] b, input logic resp);
    prod_q.push_back(b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(~b[i]);
    exp_nack.push_back(resp);
  endtask

  task automatic raise_scl();
    scl = 1'b1;
    #1;
    for (int i = 0; i < 200 && scl_line !== 1'b1; i++) @(negedge clk);
    checks++;
    if (scl_line !== 1'b1) begin
      errors++;
      $display("FAIL scl_release: scl_line=%b expected 1", scl_line);
    end
  endtask

  task automatic data_bit(input int idx);
    logic exp;
    repeat (HALF) @(negedge clk);
    exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
    checks++;
    if (sda_oe !== exp) begin
      errors++;
      $display("FAIL bit%0d_setup: sda_oe=%b expected %b", idx, sda_oe, exp);
    end
    raise_scl();
    repeat (HALF) @(negedge clk);
    checks++;
    if (sda_oe !== exp) begin
      errors++;
      $display("FAIL bit%0d_hold: sda_oe=%b expected %b", idx, sda_oe, exp);
    end
    scl = 1'b0;
  endtask

  task automatic ack_bit(input bit drop_tx);
    logic resp, got;
    int   bd0;
    resp = (exp_nack.size() > 0) ? exp_nack.pop_front() : I2C_NACK;
    repeat (HALF) @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: sda_oe=%b expected 0", sda_oe);
    end
    ctrl_sda_low = (resp == I2C_ACK);
    bd0 = bd_cnt;
    raise_scl();
    repeat (HALF) @(negedge clk);
    checks++;
    if (bd_cnt !== bd0 + 1) begin
      errors++;
      $display("FAIL byte_done_count: got %0d expected %0d", bd_cnt - bd0, 1);
    end
    got = (obs_nack.size() > 0) ? obs_nack.pop_front() : 1'bx;
    checks++;
    if (got !== resp) begin
      errors++;
      $display("FAIL nack: got %b expected %b", got, resp);
    end
    if (drop_tx) bus.tx_en = 1'b0;
    scl = 1'b0;
    ctrl_sda_low = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    reset = 1'b1;
    bus.tx_en = 1'b0;
    repeat (3) @(negedge clk);
    outs = {sda_oe, scl_oe, bus.data_ready, bus.byte_done, bus.nack, bus.underrun};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 6'b0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    outs = {sda_oe, scl_oe, bus.data_ready, bus.byte_done, bus.nack, bus.underrun};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected %b", outs, 6'b0);
    end
  endtask

  task automatic test_single_ack();
    int ur0;
    bit seen;
    ur0 = ur_cnt;
    scl = 1'b0;
    repeat (4) @(negedge clk);
    enqueue_byte(8'hA5, I2C_ACK);
    bus.tx_en = 1'b1;
    for (int i = 0; i < 8; i++) data_bit(i);
    ack_bit(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.data_ready === 1'b1) seen = 1'b1;
    end
    bus.tx_en = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reload: data_ready=%b expected 1 after ACK", bus.data_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ur_cnt !== ur0) begin
      errors++;
      $display("FAIL abort_in_load_underrun: got %0d expected %0d", ur_cnt - ur0, 0);
    end
  endtask

  task automatic test_ack_then_nack();
    int ur0;
    ur0 = ur_cnt;
    enqueue_byte(8'h3C, I2C_ACK);
    enqueue_byte(8'hFF, I2C_NACK);
    bus.tx_en = 1'b1;
    for (int i = 0; i < 8; i++) data_bit(i);
    ack_bit(1'b0);
    for (int i = 0; i < 8; i++) data_bit(8 + i);
    ack_bit(1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({sda_oe, bus.data_ready} !== 2'b00) begin
      errors++;
      $display("FAIL nack_idle: sda_oe,ready=%b expected 00", {sda_oe, bus.data_ready});
    end
    checks++;
    if (ur_cnt !== ur0) begin
      errors++;
      $display("FAIL nack_underrun: got %0d expected %0d", ur_cnt - ur0, 0);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [5:0] outs;
    enqueue_byte(8'hC3, I2C_ACK);
    bus.tx_en = 1'b1;
    for (int i = 0; i < 3; i++) data_bit(i);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    outs = {sda_oe, scl_oe, bus.data_ready, bus.byte_done, bus.nack, bus.underrun};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected %b", outs, 6'b0);
    end
    bus.tx_en = 1'b0;
    reset = 1'b0;
    exp_bits.delete();
    exp_nack.delete();
    prod_q.delete();
    repeat (4) @(negedge clk);
    enqueue_byte(8'h5A, I2C_ACK);
    bus.tx_en = 1'b1;
    for (int i = 0; i < 8; i++) data_bit(i);
    ack_bit(1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int   bd0;
    logic exp;
    bd0 = bd_cnt;
    enqueue_byte(8'h00, I2C_ACK);
    bus.tx_en = 1'b1;
    for (int i = 0; i < 4; i++) data_bit(i);
    repeat (HALF / 2) @(negedge clk);
    exp = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'bx;
    checks++;
    if (sda_oe !== exp) begin
      errors++;
      $display("FAIL abort_bit4: sda_oe=%b expected %b", sda_oe, exp);
    end
    bus.tx_en = 1'b0;
    @(negedge clk);
    checks++;
    if (sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: sda_oe=%b expected 0", sda_oe);
    end
    repeat (5) begin
      repeat (HALF) @(negedge clk);
      scl = 1'b1;
      repeat (HALF) @(negedge clk);
      scl = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bd_cnt !== bd0) begin
      errors++;
      $display("FAIL abort_byte_done: got %0d expected %0d", bd_cnt - bd0, 0);
    end
    checks++;
    if ({sda_oe, bus.data_ready} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: sda_oe,ready=%b expected 00", {sda_oe, bus.data_ready});
    end
    exp_bits.delete();
    exp_nack.delete();
  endtask

`ifdef I2C_TX_CLOCK_STRETCH_EN
  task automatic test_stretch();
    int bad;
    int ur0;
    bit found;
    ur0 = ur_cnt;
    bus.tx_en = 1'b1;
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (scl_oe !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stretch_hold: scl_oe low in %0d cycles expected %0d", bad, 0);
    end
    enqueue_byte(8'h80, I2C_ACK);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || scl_oe !== 1'b1) begin
      errors++;
      $display("FAIL stretch_handshake: found=%b scl_oe=%b expected 1 1", found, scl_oe);
    end
    @(negedge clk);
    checks++;
    if (scl_oe !== 1'b0) begin
      errors++;
      $display("FAIL stretch_drop: scl_oe=%b expected 0", scl_oe);
    end
    for (int i = 0; i < 8; i++) data_bit(i);
    ack_bit(1'b1);
    checks++;
    if (ur_cnt !== ur0) begin
      errors++;
      $display("FAIL stretch_underrun: got %0d expected %0d", ur_cnt - ur0, 0);
    end
  endtask
`else
  task automatic test_underrun();
    int ur0;
    ur0 = ur_cnt;
    for (int i = 0; i < 8; i++) exp_bits.push_back(1'b0);
    exp_nack.push_back(I2C_ACK);
    bus.tx_en = 1'b1;
    data_bit(0);
    checks++;
    if (ur_cnt !== ur0 + 1) begin
      errors++;
      $display("FAIL underrun_pulse: got %0d expected %0d", ur_cnt - ur0, 1);
    end
    for (int i = 1; i < 8; i++) data_bit(i);
    ack_bit(1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (ur_cnt !== ur0 + 1) begin
      errors++;
      $display("FAIL underrun_single: got %0d expected %0d", ur_cnt - ur0, 1);
    end
  endtask
`endif

  initial begin
    bus.tx_en = 1'b0;
    test_reset();
    test_single_ack();
    test_ack_then_nack();
    test_reset_mid_shift();
    test_abort();
`ifdef I2C_TX_CLOCK_STRETCH_EN
    test_stretch();
`else
    test_underrun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
